// File: rtl/mem_port_arbiter.sv
//============================================================================
// mem_port_arbiter : shares a single-port memory between IF and DM requesters.
// Optional macro MEM_ARB_RR_EN selects round-robin tie-breaking.
// Rev 1.0
//============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              If_Req,
  input  logic [ADDR_W-1:0] If_Addr,
  output logic              If_Gnt,
  output logic              If_Rvalid,
  output logic [DATA_W-1:0] If_Rdata,
  input  logic              Dm_Req,
  input  logic              Dm_We,
  input  logic [ADDR_W-1:0] Dm_Addr,
  input  logic [DATA_W-1:0] Dm_Wdata,
  output logic              Dm_Gnt,
  output logic              Dm_Rvalid,
  output logic [DATA_W-1:0] Dm_Rdata,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Wdata,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic              Busy
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_access = 2'd1;
  localparam logic [1:0] c_resp   = 2'd2;
  localparam logic [3:0] c_lat_m1 = 4'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_owner_dm;
  logic              r_if_rvalid;
  logic              r_dm_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              w_pick_dm;
  logic              w_idle;
  logic              w_grant;

`ifdef MEM_ARB_RR_EN
  logic              r_last_dm;

  // Last-granted pointer; reset to IF so the first tie goes to DM.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_last_dm <= 1'b0;
    end else if (w_grant) begin
      r_last_dm <= Dm_Gnt;
    end
  end
`endif

  always_comb begin
    w_pick_dm = Dm_Req;
`ifdef MEM_ARB_RR_EN
    if (Dm_Req && If_Req) begin
      w_pick_dm = !r_last_dm;
    end
`endif
  end

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:   if (w_grant) w_state_nxt = c_access;
      c_access: if (r_cnt == 4'd0) w_state_nxt = c_resp;
      c_resp:   w_state_nxt = c_idle;
      default:  w_state_nxt = c_idle;
    endcase
  end

  // Output decode; grants are the only outputs that see the request inputs.
  always_comb begin
    w_idle    = (r_state == c_idle);
    If_Gnt    = w_idle && !Reset && If_Req && !w_pick_dm;
    Dm_Gnt    = w_idle && !Reset && Dm_Req && w_pick_dm;
    w_grant   = If_Gnt || Dm_Gnt;
    Mem_En    = (r_state == c_access);
    Mem_We    = Mem_En && r_we;
    Mem_Addr  = Mem_En ? r_addr : '0;
    Mem_Wdata = Mem_En ? r_wdata : '0;
    Busy      = !w_idle;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_owner_dm  <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_grant) begin
            r_owner_dm <= Dm_Gnt;
            r_addr     <= Dm_Gnt ? Dm_Addr : If_Addr;
            r_wdata    <= Dm_Gnt ? Dm_Wdata : '0;
            r_we       <= Dm_Gnt && Dm_We;
            r_cnt      <= c_lat_m1;
          end
        end
        c_access: begin
          if (r_cnt == 4'd0) begin
            // Stores leave the owner's read-data register untouched.
            if (!r_we) begin
              if (r_owner_dm) begin
                r_dm_rdata <= Mem_Rdata;
              end else begin
                r_if_rdata <= Mem_Rdata;
              end
            end
            r_dm_rvalid <= r_owner_dm;
            r_if_rvalid <= !r_owner_dm;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign If_Rvalid = r_if_rvalid;
  assign If_Rdata  = r_if_rdata;
  assign Dm_Rvalid = r_dm_rvalid;
  assign Dm_Rdata  = r_dm_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//============================================================================
// tb_mem_port_arbiter : directed scoreboard bench for mem_port_arbiter.
// Rev 1.0
//============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        CLK;
  logic        Reset;
  logic        If_Req, Dm_Req, Dm_We;
  logic [31:0] If_Addr, Dm_Addr, Dm_Wdata;
  logic        If_Gnt, If_Rvalid, Dm_Gnt, Dm_Rvalid, Mem_En, Mem_We, Busy;
  logic [31:0] If_Rdata, Dm_Rdata, Mem_Addr, Mem_Wdata, Mem_Rdata;

  logic        If_Req_1;
  logic [31:0] If_Addr_1;
  logic        If_Gnt_1, If_Rvalid_1, Dm_Gnt_1, Dm_Rvalid_1, Mem_En_1, Mem_We_1, Busy_1;
  logic [31:0] If_Rdata_1, Dm_Rdata_1, Mem_Addr_1, Mem_Wdata_1, Mem_Rdata_1;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'hDEAD_BEEF;
      32'h0000_0200: return 32'hCAFE_F00D;
      default:       return {16'h0BAD, a[15:0]};
    endcase
  endfunction

  assign Mem_Rdata   = mem_model(Mem_Addr);
  assign Mem_Rdata_1 = mem_model(Mem_Addr_1);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
    .CLK(CLK), .Reset(Reset),
    .If_Req(If_Req), .If_Addr(If_Addr), .If_Gnt(If_Gnt),
    .If_Rvalid(If_Rvalid), .If_Rdata(If_Rdata),
    .Dm_Req(Dm_Req), .Dm_We(Dm_We), .Dm_Addr(Dm_Addr), .Dm_Wdata(Dm_Wdata),
    .Dm_Gnt(Dm_Gnt), .Dm_Rvalid(Dm_Rvalid), .Dm_Rdata(Dm_Rdata),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
    .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .Busy(Busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
    .CLK(CLK), .Reset(Reset),
    .If_Req(If_Req_1), .If_Addr(If_Addr_1), .If_Gnt(If_Gnt_1),
    .If_Rvalid(If_Rvalid_1), .If_Rdata(If_Rdata_1),
    .Dm_Req(1'b0), .Dm_We(1'b0), .Dm_Addr(32'h0), .Dm_Wdata(32'h0),
    .Dm_Gnt(Dm_Gnt_1), .Dm_Rvalid(Dm_Rvalid_1), .Dm_Rdata(Dm_Rdata_1),
    .Mem_En(Mem_En_1), .Mem_We(Mem_We_1), .Mem_Addr(Mem_Addr_1),
    .Mem_Wdata(Mem_Wdata_1), .Mem_Rdata(Mem_Rdata_1), .Busy(Busy_1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("idle_timeout", 32'(Busy), 32'd0);
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!Reset) begin
      if (If_Rvalid) begin
        if (if_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL if_rvalid_unexpected: got pulse expected none at %0t", $time);
        end else begin
          chk("if_rdata", If_Rdata, if_q.pop_front());
        end
      end
      if (Dm_Rvalid) begin
        if (dm_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL dm_rvalid_unexpected: got pulse expected none at %0t", $time);
        end else begin
          chk("dm_rdata", Dm_Rdata, dm_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; If_Req = 1'b0; Dm_Req = 1'b0; Dm_We = 1'b0;
    If_Addr = '0; Dm_Addr = '0; Dm_Wdata = '0; If_Req_1 = 1'b0; If_Addr_1 = '0;
    repeat (2) @(negedge CLK);
    If_Req = 1'b1; If_Addr = 32'h40;
    #1;
    chk("gnt_during_reset", 32'({If_Gnt, Dm_Gnt}), 32'd0);
    chk("reset_ctrl", 32'({Mem_En, Mem_We, Busy, If_Rvalid, Dm_Rvalid}), 32'd0);
    chk("reset_rdata", If_Rdata | Dm_Rdata | Mem_Addr | Mem_Wdata, 32'd0);
    If_Req = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;

    // Single IF read
    @(negedge CLK);
    If_Req = 1'b1; If_Addr = 32'h40;
    #1 chk("if_gnt", 32'({If_Gnt, Dm_Gnt}), 32'b10);
    if_q.push_back(32'hDEAD_BEEF);
    @(negedge CLK);
    If_Req = 1'b0;
    #1 chk("if_access_t1", 32'({Mem_En, Mem_We, Busy}), 32'b101);
    chk("if_addr_t1", Mem_Addr, 32'h40);
    @(negedge CLK);
    #1 chk("if_access_t2", 32'({Mem_En, Mem_We}), 32'b10);
    chk("if_addr_t2", Mem_Addr, 32'h40);
    @(negedge CLK);
    #1 chk("if_resp_t3", 32'({Mem_En, If_Rvalid, Dm_Rvalid}), 32'b010);
    @(negedge CLK);
    #1 chk("if_idle_t4", 32'(Busy), 32'd0);

    // DM load
    @(negedge CLK);
    Dm_Req = 1'b1; Dm_We = 1'b0; Dm_Addr = 32'h200;
    #1 chk("dm_load_gnt", 32'({If_Gnt, Dm_Gnt}), 32'b01);
    dm_q.push_back(32'hCAFE_F00D);
    @(negedge CLK);
    Dm_Req = 1'b0;
    #1 wait_idle();

    // DM store: read data register must keep the previous load value
    @(negedge CLK);
    Dm_Req = 1'b1; Dm_We = 1'b1; Dm_Addr = 32'h100; Dm_Wdata = 32'h1234_5678;
    #1 chk("dm_store_gnt", 32'({If_Gnt, Dm_Gnt}), 32'b01);
    dm_q.push_back(32'hCAFE_F00D);
    for (int c = 1; c <= 2; c++) begin
      @(negedge CLK);
      Dm_Req = 1'b0;
      #1 chk("store_we", 32'({Mem_En, Mem_We}), 32'b11);
      chk("store_addr", Mem_Addr, 32'h100);
      chk("store_wdata", Mem_Wdata, 32'h1234_5678);
    end
    @(negedge CLK);
    #1 chk("store_we_done", 32'(Mem_We), 32'd0);
    Dm_We = 1'b0;
    wait_idle();

    // Tie: both requesters held for four grant slots
    @(negedge CLK);
    Dm_Req = 1'b1; If_Req = 1'b1; Dm_Addr = 32'h200; If_Addr = 32'h40;
    for (int c = 0; c < 16; c++) begin
      logic [1:0] exp_gnt;
      if (c != 0) @(negedge CLK);
      #1;
      exp_gnt = 2'b00;
      if (c % 4 == 0) begin
`ifdef MEM_ARB_RR_EN
        exp_gnt = ((c / 4) % 2 == 1) ? 2'b10 : 2'b01;
`else
        exp_gnt = 2'b01;
`endif
        if (exp_gnt == 2'b01) dm_q.push_back(32'hCAFE_F00D);
        else                  if_q.push_back(32'hDEAD_BEEF);
      end
      chk("tie_gnt", 32'({If_Gnt, Dm_Gnt}), 32'(exp_gnt));
    end
    @(negedge CLK);
    Dm_Req = 1'b0; If_Req = 1'b0;
    #1 wait_idle();

    // MEM_LAT=1 instance
    @(negedge CLK);
    If_Req_1 = 1'b1; If_Addr_1 = 32'h44;
    #1 chk("lat1_gnt", 32'(If_Gnt_1), 32'd1);
    @(negedge CLK);
    If_Req_1 = 1'b0;
    #1 chk("lat1_access", 32'({Mem_En_1, Busy_1}), 32'b11);
    @(negedge CLK);
    #1 chk("lat1_rvalid", 32'({Mem_En_1, If_Rvalid_1}), 32'b01);
    chk("lat1_rdata", If_Rdata_1, 32'h0BAD_0044);
    @(negedge CLK);
    If_Req_1 = 1'b1;
    #1 chk("lat1_regrant", 32'(If_Gnt_1), 32'd1);
    @(negedge CLK);
    If_Req_1 = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset during the first ACCESS cycle of a store
    Dm_Req = 1'b1; Dm_We = 1'b1; Dm_Addr = 32'h300; Dm_Wdata = 32'h0000_55AA;
    #1 chk("rst_store_gnt", 32'({If_Gnt, Dm_Gnt}), 32'b01);
    @(negedge CLK);
    Dm_Req = 1'b0; Dm_We = 1'b0; Reset = 1'b1; If_Req = 1'b1; If_Addr = 32'h80;
    #1 chk("rst_first_access", 32'({Mem_En, Mem_We, If_Gnt}), 32'b110);
    @(negedge CLK);
    Reset = 1'b0;
    #1 chk("rst_mem_off", 32'({Mem_En, Mem_We, Busy, Dm_Rvalid}), 32'd0);
    chk("rst_dm_rdata", Dm_Rdata, 32'd0);
    chk("rst_if_regrant", 32'({If_Gnt, Dm_Gnt}), 32'b10);
    if_q.push_back(32'h0BAD_0080);
    @(negedge CLK);
    If_Req = 1'b0;
    #1 wait_idle();

    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", 32'(if_q.size() + dm_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
